// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the round-robin request arbiter.
package arbiter_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

  localparam int unsigned DefaultDataW = 8;

  // Width of a port index; never zero so single-port builds still elaborate.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester after the last-served index wins.
module rr_picker
  import arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]               req_i,
  input  logic [idx_width(NUM_PORTS)-1:0]    last_i,
  output logic [idx_width(NUM_PORTS)-1:0]    winner_o,
  output logic                               any_req_o
);

  localparam int unsigned IdxW = idx_width(NUM_PORTS);

  int unsigned         cand;
  logic [IdxW-1:0]     cand_idx;

  // Walk offsets from farthest to nearest so the nearest requester overrides.
  always_comb begin
    winner_o  = '0;
    any_req_o = |req_i;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned off = NUM_PORTS; off > 0; off--) begin
      cand     = (32'(last_i) + off) % NUM_PORTS;
      cand_idx = cand[IdxW-1:0];
      if (req_i[cand_idx]) begin
        winner_o = cand_idx;
      end
    end
  end

endmodule

// File: rtl/req_arbiter.sv
// Responder for the req/busy writer handshake: round-robin grant, single output register.
// Optional capture counter output o_count enabled by defining ARBITER_COUNT_EN.
module req_arbiter
  import arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned DATA_W    = DefaultDataW
) (
  input  logic                              i_clk,
  input  logic                              i_reset_n,
  input  logic [NUM_PORTS-1:0]              i_req,
  input  logic [NUM_PORTS*DATA_W-1:0]       i_data,
  output logic [NUM_PORTS-1:0]              o_busy,
  output logic                              o_valid,
  output logic [DATA_W-1:0]                 o_data,
  output logic [idx_width(NUM_PORTS)-1:0]   o_id,
`ifdef ARBITER_COUNT_EN
  output logic [15:0]                       o_count,
`endif
  input  logic                              i_ready
);

  localparam int unsigned IdxW = idx_width(NUM_PORTS);

  state_e                state_q, state_d;
  logic [IdxW-1:0]       grant_q, grant_d;
  logic [IdxW-1:0]       last_q, last_d;
  logic [NUM_PORTS-1:0]  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [IdxW-1:0]       id_q, id_d;
  logic [IdxW-1:0]       winner;
  logic                  any_req;
  logic                  capture;

  rr_picker #(
    .NUM_PORTS (NUM_PORTS)
  ) u_picker (
    .req_i     (i_req),
    .last_i    (last_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    busy_d  = '1;
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    capture = 1'b0;

    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        // Only grant when the output register is empty or draining this edge.
        if (any_req && (!valid_q || i_ready)) begin
          state_d        = StGrant;
          grant_d        = winner;
          busy_d[winner] = 1'b0;
        end
      end
      StGrant: begin
        // A withdrawn request is dropped without touching the rr pointer.
        if (i_req[grant_q]) begin
          capture = 1'b1;
          data_d  = i_data[grant_q*DATA_W +: DATA_W];
          id_d    = grant_q;
          valid_d = 1'b1;
          last_d  = grant_q;
        end
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IdxW'(NUM_PORTS - 1);
      busy_q  <= '1;
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_id    = id_q;

`ifdef ARBITER_COUNT_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (capture && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

  a_one_grant: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    $countones(~busy_q) <= 1);

  a_no_grant_while_stalled: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (state_q == StIdle && valid_q && !i_ready) |=> (busy_q == '1));

endmodule

// File: tb/tb_req_arbiter.sv
// Directed scoreboard bench for req_arbiter (2 ports, 8-bit data).
module tb_req_arbiter;

  localparam int unsigned NUM_PORTS = 2;
  localparam int unsigned DATA_W    = 8;

  logic                        i_clk = 1'b0;
  logic                        i_reset_n = 1'b0;
  logic [NUM_PORTS-1:0]        i_req = '0;
  logic [NUM_PORTS*DATA_W-1:0] i_data = '0;
  logic                        i_ready = 1'b1;
  logic [NUM_PORTS-1:0]        o_busy;
  logic                        o_valid;
  logic [DATA_W-1:0]           o_data;
  logic [0:0]                  o_id;
`ifdef ARBITER_COUNT_EN
  logic [15:0]                 o_count;
`endif

  int checks = 0;
  int failures = 0;
  logic [8:0] sb_q[$];

  req_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .DATA_W    (DATA_W)
  ) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_req     (i_req),
    .i_data    (i_data),
    .o_busy    (o_busy),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_id      (o_id),
`ifdef ARBITER_COUNT_EN
    .o_count   (o_count),
`endif
    .i_ready   (i_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle; a writer drops req after an edge where it saw busy low.
  task automatic step();
    logic [NUM_PORTS-1:0] xfer;
    @(negedge i_clk);
    xfer = i_req & ~o_busy;
    @(posedge i_clk);
    #1;
    i_req = i_req & ~xfer;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    i_req     = '0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
  endtask

  task automatic set_data(input int port, input logic [7:0] val);
    i_data[port*DATA_W +: DATA_W] = val;
  endtask

  task automatic expect_out(input logic id, input logic [7:0] data);
    sb_q.push_back({id, data});
  endtask

  task automatic monitor();
    logic [8:0] e;
    forever begin
      @(negedge i_clk);
      if (i_reset_n) begin
        check("busy_onehot", 32'($countones(~o_busy) <= 1), 32'd1);
        if (o_valid && i_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected actual=id%0d/%0h required=none at %0t",
                     o_id, o_data, $time);
          end else begin
            e = sb_q.pop_front();
            check("sb_data", 32'(o_data), 32'(e[7:0]));
            check("sb_id", 32'(o_id), 32'(e[8]));
          end
        end
      end
    end
  endtask

  task automatic run_tests();
    do_reset();
    check("rst_busy", 32'(o_busy), 32'h3);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_data", 32'(o_data), 32'h0);
    check("rst_id", 32'(o_id), 32'h0);

    // Single writer on port 0, repeated requests.
    for (int r = 0; r < 3; r++) begin
      set_data(0, 8'h05);
      i_req[0] = 1'b1;
      expect_out(1'b0, 8'h05);
      step();
      check("t1_busy_low", 32'(o_busy), 32'h2);
      step();
      check("t1_busy_high", 32'(o_busy), 32'h3);
      check("t1_valid", 32'(o_valid), 32'h1);
      step();
      check("t1_valid_clr", 32'(o_valid), 32'h0);
    end

    // Simultaneous requests after reset: port 0 then port 1.
    do_reset();
    set_data(0, 8'hA0);
    set_data(1, 8'hB1);
    i_req = 2'b11;
    expect_out(1'b0, 8'hA0);
    expect_out(1'b1, 8'hB1);
    step();
    check("t2_grant0", 32'(o_busy), 32'h2);
    step();
    check("t2_cap0_busy", 32'(o_busy), 32'h3);
    check("t2_cap0_valid", 32'(o_valid), 32'h1);
    step();
    check("t2_grant1", 32'(o_busy), 32'h1);
    check("t2_drain", 32'(o_valid), 32'h0);
    step();
    check("t2_cap1_valid", 32'(o_valid), 32'h1);
    check("t2_cap1_busy", 32'(o_busy), 32'h3);
    step();
    check("t2_idle", 32'(o_valid), 32'h0);

    // Backpressure holds output and blocks grants.
    i_ready = 1'b0;
    set_data(0, 8'h3C);
    i_req = 2'b01;
    expect_out(1'b0, 8'h3C);
    step();
    step();
    set_data(1, 8'h5D);
    i_req[1] = 1'b1;
    expect_out(1'b1, 8'h5D);
    for (int c = 0; c < 10; c++) begin
      step();
      check("t3_hold_valid", 32'(o_valid), 32'h1);
      check("t3_hold_data", 32'(o_data), 32'h3C);
      check("t3_hold_busy", 32'(o_busy), 32'h3);
    end
    i_ready = 1'b1;
    step();
    check("t3_grant_after_ready", 32'(o_busy), 32'h1);
    check("t3_drained", 32'(o_valid), 32'h0);
    step();
    check("t3_cap1", 32'(o_valid), 32'h1);
    step();
    check("t3_idle", 32'(o_valid), 32'h0);

    // Serve port 0 so the pointer favours port 1 next.
    set_data(0, 8'h11);
    i_req = 2'b01;
    expect_out(1'b0, 8'h11);
    steps(3);

    // Port 1 withdraws during its grant.
    set_data(1, 8'h77);
    i_req = 2'b10;
    step();
    check("t4_grant1", 32'(o_busy), 32'h1);
    i_req[1] = 1'b0;
    step();
    check("t4_busy_back", 32'(o_busy), 32'h3);
    check("t4_no_valid", 32'(o_valid), 32'h0);
    step();
    check("t4_still_none", 32'(o_valid), 32'h0);
    set_data(0, 8'h22);
    set_data(1, 8'h33);
    i_req = 2'b11;
    expect_out(1'b1, 8'h33);
    expect_out(1'b0, 8'h22);
    step();
    check("t4_port1_first", 32'(o_busy), 32'h1);
    steps(2);
    check("t4_then_port0", 32'(o_busy), 32'h2);
    steps(2);
    check("t4_idle", 32'(o_valid), 32'h0);

    // Asynchronous reset in the middle of a grant.
    set_data(0, 8'h44);
    i_req = 2'b01;
    step();
    check("t5_in_grant", 32'(o_busy), 32'h2);
    #2;
    i_reset_n = 1'b0;
    i_req     = '0;
    #1;
    check("t5_async_busy", 32'(o_busy), 32'h3);
    check("t5_async_valid", 32'(o_valid), 32'h0);
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    set_data(0, 8'h81);
    set_data(1, 8'h92);
    i_req = 2'b11;
    expect_out(1'b0, 8'h81);
    expect_out(1'b1, 8'h92);
    step();
    check("t5_port0_first", 32'(o_busy), 32'h2);
    steps(4);
    check("t5_idle", 32'(o_valid), 32'h0);
`ifdef ARBITER_COUNT_EN
    check("count", 32'(o_count), 32'd2);
`endif

    check("sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    fork
      monitor();
      run_tests();
      begin
        #200000;
        checks++;
        failures++;
        $display("FAIL watchdog actual=timeout required=completion");
      end
    join_any
    disable fork;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
